// File: rtl/cmp_pkg.sv
// Shared types for the comparator result tracker: FSM states, result codes and
// the one-hot decode of the comparator outputs.
package cmp_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StTrack  = 2'b01,
    StLocked = 2'b10,
    StFault  = 2'b11
  } state_e;

  typedef enum logic [1:0] {
    RES_NONE = 2'b00,
    RES_LT   = 2'b01,
    RES_EQ   = 2'b10,
    RES_GT   = 2'b11
  } res_e;

  typedef struct packed {
    logic legal;
    res_e code;
  } decode_t;

  // Anything other than exactly one of lt/eq/gt is illegal and reports RES_NONE.
  function automatic decode_t decode_res(input logic lt, input logic eq, input logic gt);
    decode_t d;
    d.legal = 1'b1;
    unique case ({lt, eq, gt})
      3'b100:  d.code = RES_LT;
      3'b010:  d.code = RES_EQ;
      3'b001:  d.code = RES_GT;
      default: begin
        d.code  = RES_NONE;
        d.legal = 1'b0;
      end
    endcase
    return d;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/cmp_result_tracker.sv
// Registered consumer of lt/eq/gt comparator results: per-outcome saturating
// counts, eq-streak lock detection and a sticky fault on illegal codes.
module cmp_result_tracker
  import cmp_pkg::*;
#(
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned STABLE_N = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  input  logic             lt,
  input  logic             eq,
  input  logic             gt,
  output logic [CNT_W-1:0] lt_cnt,
  output logic [CNT_W-1:0] eq_cnt,
  output logic [CNT_W-1:0] gt_cnt,
  output logic [1:0]       last_res,
  output logic             match,
  output logic             err,
  output logic [1:0]       state
);

  localparam int unsigned StreakW = $clog2(STABLE_N + 1);
  localparam logic [StreakW-1:0] StreakMax = StreakW'(STABLE_N);

  state_e             state_q, state_d;
  logic [StreakW-1:0] streak_q, streak_d;
  res_e               last_res_q, last_res_d;
  decode_t            dec;
  logic               accept;

  assign dec = decode_res(lt, eq, gt);
  // FAULT freezes everything; only clr or reset releases it.
  assign accept = in_valid && !clr && (state_q != StFault);

  always_comb begin
    state_d    = state_q;
    streak_d   = streak_q;
    last_res_d = last_res_q;
    if (clr) begin
      state_d    = StIdle;
      streak_d   = '0;
      last_res_d = RES_NONE;
    end else if (accept) begin
      if (!dec.legal) begin
        state_d = StFault;
      end else begin
        last_res_d = dec.code;
        if (dec.code == RES_EQ) begin
          streak_d = (streak_q == StreakMax) ? streak_q : streak_q + 1'b1;
          state_d  = (streak_d == StreakMax) ? StLocked : StTrack;
        end else begin
          streak_d = '0;
          state_d  = StTrack;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      streak_q   <= '0;
      last_res_q <= RES_NONE;
    end else begin
      state_q    <= state_d;
      streak_q   <= streak_d;
      last_res_q <= last_res_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_lt_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .inc   (accept && dec.legal && (dec.code == RES_LT)),
    .cnt   (lt_cnt)
  );

  sat_counter #(.W(CNT_W)) u_eq_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .inc   (accept && dec.legal && (dec.code == RES_EQ)),
    .cnt   (eq_cnt)
  );

  sat_counter #(.W(CNT_W)) u_gt_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .inc   (accept && dec.legal && (dec.code == RES_GT)),
    .cnt   (gt_cnt)
  );

  assign last_res = last_res_q;
  assign state    = state_q;
  assign match    = (state_q == StLocked);
  assign err      = (state_q == StFault);

endmodule
